// File: rtl/receiver_pkg.sv
// Shared constants and helpers for the frame checksum receiver.
// Holds the default frame geometry, the all-ones "checksum good" pattern
// and the end-around-carry add used by the adder chain.
package receiver_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_WORDS = 3;

  localparam logic [DEFAULT_WIDTH-1:0] ALL_ONES = {DEFAULT_WIDTH{1'b1}};

  // One's-complement add: the carry out of the top bit wraps back into bit 0.
  function automatic logic [DEFAULT_WIDTH-1:0] oc_add(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b
  );
    logic [DEFAULT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEFAULT_WIDTH-1:0] + {{(DEFAULT_WIDTH-1){1'b0}}, s[DEFAULT_WIDTH]};
  endfunction

endpackage

// File: rtl/ones_complement_adder.sv
// Combinational WIDTH-bit one's-complement adder (end-around carry).
// The default width reuses the package helper; other widths use the same
// arithmetic written out for the parameterised width.
module ones_complement_adder
  import receiver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  generate
    if (WIDTH == DEFAULT_WIDTH) begin : g_pkg_add
      // Default width: share the package function so there is one definition of the add.
      always_comb begin
        sum = oc_add(a, b);
      end
    end else begin : g_generic_add
      logic [WIDTH:0] wide;

      // Other widths: add with one extra bit, then fold the carry back into the LSB.
      always_comb begin
        wide = {1'b0, a} + {1'b0, b};
        sum  = wide[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, wide[WIDTH]};
      end
    end
  endgenerate

endmodule

// File: rtl/receiver.sv
// Frame checksum receiver.
// Folds all WORDS words of a frame (checksum word included) through a chain of
// one's-complement adders and flags the frame good when the result is all ones.
// ok/ok_valid are registered one cycle after data_valid.
// Optional feature: define RECEIVER_ERR_COUNT_EN to enable the saturating
// failed-frame counter on err_count; otherwise err_count reads as zero.
module receiver
  import receiver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_valid,
  input  logic [WORDS*WIDTH-1:0] data,
  output logic                   ok_valid,
  output logic                   ok,
  output logic [15:0]            err_count
);

  logic [WIDTH-1:0] partial [WORDS];
  logic [WIDTH-1:0] good_pattern;
  logic             frame_good;

  // Word 0 sits in the top bits of the frame and seeds the fold.
  assign partial[0] = data[WORDS*WIDTH-1 -: WIDTH];

  generate
    for (genvar i = 1; i < WORDS; i++) begin : g_chain
      ones_complement_adder #(
        .WIDTH (WIDTH)
      ) u_add (
        .a   (partial[i-1]),
        .b   (data[WORDS*WIDTH-1-i*WIDTH -: WIDTH]),
        .sum (partial[i])
      );
    end

    if (WIDTH == DEFAULT_WIDTH) begin : g_pat_pkg
      assign good_pattern = ALL_ONES;
    end else begin : g_pat_generic
      assign good_pattern = {WIDTH{1'b1}};
    end
  endgenerate

  // Any-width all-ones result (including negative zero from an all-ones frame) is a good frame.
  always_comb begin
    frame_good = (partial[WORDS-1] == good_pattern);
  end

  // Output stage: reset wins over a frame in the same cycle; ok holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_valid <= 1'b0;
      ok       <= 1'b0;
    end else begin
      ok_valid <= data_valid;
      if (data_valid) begin
        ok <= frame_good;
      end
    end
  end

`ifdef RECEIVER_ERR_COUNT_EN
  logic [15:0] err_cnt;

  // Count accepted bad frames, sticking at the maximum rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 16'h0000;
    end else if (data_valid && !frame_good && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end

  assign err_count = err_cnt;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_receiver.sv
// Directed testbench for the frame checksum receiver (WIDTH=16, WORDS=3).
// Expected results are hand-computed one's-complement sums of each frame.
module tb_receiver;

  logic        clk;
  logic        rst;
  logic        dataValid;
  logic [47:0] data;
  logic        okValid;
  logic        ok;
  logic [15:0] errCount;

  int vectors;
  int miscompares;
  logic [15:0] expErr;

`ifdef RECEIVER_ERR_COUNT_EN
  localparam logic [15:0] ERR_STEP = 16'd1;
`else
  localparam logic [15:0] ERR_STEP = 16'd0;
`endif

  receiver #(
    .WIDTH (16),
    .WORDS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (dataValid),
    .data       (data),
    .ok_valid   (okValid),
    .ok         (ok),
    .err_count  (errCount)
  );

  // 10 ns free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs on the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [47:0] frame);
    @(negedge clk);
    rst       = r;
    dataValid = v;
    data      = frame;
    @(posedge clk);
    #1;
  endtask

  // Compare registered outputs against hand-computed expectations.
  task automatic checkOutput(input string tag, input logic expValid, input logic expOk,
                             input logic [15:0] expCnt);
    vectors++;
    assert (okValid === expValid) else begin
      miscompares++;
      $error("[TB] FAIL %s ok_valid: got %b, want %b", tag, okValid, expValid);
    end
    vectors++;
    assert (ok === expOk) else begin
      miscompares++;
      $error("[TB] FAIL %s ok: got %b, want %b", tag, ok, expOk);
    end
    vectors++;
    assert (errCount === expCnt) else begin
      miscompares++;
      $error("[TB] FAIL %s err_count: got %h, want %h", tag, errCount, expCnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    expErr      = 16'h0000;
    rst         = 1'b1;
    dataValid   = 1'b0;
    data        = 48'h0;

    applyStimulus(1'b1, 1'b0, 48'h0);
    applyStimulus(1'b1, 1'b0, 48'h0);
    checkOutput("reset", 1'b0, 1'b0, 16'h0000);

    // 9D2D+C3D5 = 6103 after wrap, +9EFC = FFFF
    applyStimulus(1'b0, 1'b1, 48'h9D2D_C3D5_9EFC);
    checkOutput("good_frame", 1'b1, 1'b1, expErr);

    // 6103+9EFD = 0001 after wrap
    applyStimulus(1'b0, 1'b1, 48'h9D2D_C3D5_9EFD);
    expErr = expErr + ERR_STEP;
    checkOutput("bad_checksum_lsb", 1'b1, 1'b0, expErr);

    // 9D2D+E7D5 = 8503, +9EFC = 2400; then the good frame back-to-back
    applyStimulus(1'b0, 1'b1, 48'h9D2D_E7D5_9EFC);
    expErr = expErr + ERR_STEP;
    checkOutput("bad_payload", 1'b1, 1'b0, expErr);
    applyStimulus(1'b0, 1'b1, 48'h9D2D_C3D5_9EFC);
    checkOutput("b2b_good", 1'b1, 1'b1, expErr);

    applyStimulus(1'b0, 1'b1, 48'h0000_0000_0000);
    expErr = expErr + ERR_STEP;
    checkOutput("all_zero", 1'b1, 1'b0, expErr);

    applyStimulus(1'b0, 1'b1, 48'hFFFF_FFFF_FFFF);
    checkOutput("all_ones", 1'b1, 1'b1, expErr);

    // 0001+0002 = 0003, +FFFC = FFFF with no carry at all
    applyStimulus(1'b0, 1'b1, 48'h0001_0002_FFFC);
    checkOutput("no_carry_good", 1'b1, 1'b1, expErr);

    // 8000+8000 = 0001 after wrap, +FFFE = FFFF
    applyStimulus(1'b0, 1'b1, 48'h8000_8000_FFFE);
    checkOutput("carry_wrap_good", 1'b1, 1'b1, expErr);

    // 0000+1234 = 1234, +EDCA = FFFE: one bit short of all ones
    applyStimulus(1'b0, 1'b1, 48'h0000_1234_EDCA);
    expErr = expErr + ERR_STEP;
    checkOutput("near_miss", 1'b1, 1'b0, expErr);
    applyStimulus(1'b0, 1'b1, 48'h0000_1234_EDCB);
    checkOutput("near_miss_fixed", 1'b1, 1'b1, expErr);

    // Idle with a bad frame on the bus: nothing accepted, ok holds 1
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 48'h0000_0000_0000);
      checkOutput($sformatf("idle_%0d", i), 1'b0, 1'b1, expErr);
    end

    // Reset together with a good frame: frame dropped, everything cleared
    applyStimulus(1'b1, 1'b1, 48'h9D2D_C3D5_9EFC);
    expErr = 16'h0000;
    checkOutput("reset_with_frame", 1'b0, 1'b0, expErr);
    applyStimulus(1'b0, 1'b0, 48'h9D2D_C3D5_9EFC);
    checkOutput("after_reset_idle", 1'b0, 1'b0, expErr);

`ifdef RECEIVER_ERR_COUNT_EN
    // Preload the counter at its maximum, then a bad frame must not wrap it
    @(negedge clk);
    force dut.err_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.err_cnt;
    applyStimulus(1'b0, 1'b1, 48'h9D2D_C3D5_9EFD);
    checkOutput("err_saturate", 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 48'h0000_0000_0000);
    checkOutput("err_saturate_hold", 1'b1, 1'b0, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
